// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, default idle fill byte and responder state encoding.
// The master reuses SPI_BITS so both ends agree on the frame size.
package spi_pkg;

    localparam int SPI_BITS = 8;
    localparam int CNT_W    = $clog2(SPI_BITS);

    localparam logic [SPI_BITS-1:0] IDLE_FILL_DEFAULT = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one asynchronous input pin, with a selectable reset level
// so an idle-high pin (chip select) does not look like an active edge coming out of reset.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_pin
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign o_pin = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder running in the raw_clk domain: oversampled pins, MSB-first 8-bit
// frames, and a byte-level CPU interface with strobe/ready/clear handshakes.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                  SYNC_STAGES = 2,
    parameter logic [SPI_BITS-1:0] IDLE_FILL   = IDLE_FILL_DEFAULT
) (
    input  logic                raw_clk,
    input  logic                reset,
    input  logic                spi_sclk,
    input  logic                spi_cs,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_strobe,
    output logic                tx_pending,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_ready,
    input  logic                rx_ready_clear,
    output logic                overrun,
    input  logic                overrun_clear,
    output logic                cs_active
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .i_clk(raw_clk), .i_rst_n(reset), .i_pin(spi_sclk), .o_pin(w_sclk_s));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .i_clk(raw_clk), .i_rst_n(reset), .i_pin(spi_cs), .o_pin(w_cs_s));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk(raw_clk), .i_rst_n(reset), .i_pin(spi_mosi), .o_pin(w_mosi_s));

    spi_state_t            r_state;
    logic                  r_sclk_prev;
    logic                  r_cs_prev;
    logic [SYNC_STAGES:0]  r_flush;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [SPI_BITS-2:0]   r_rx_shift;
    logic [SPI_BITS-1:0]   r_tx_shift;
    logic [SPI_BITS-1:0]   r_tx_buf;
    logic                  r_tx_pending;
    logic [SPI_BITS-1:0]   r_rx_data;
    logic                  r_rx_ready;
    logic                  r_overrun;
    logic                  r_miso_oe;

    logic                  w_armed;
    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_cs_fall;
    logic                  w_cs_rise;
    logic [SPI_BITS-1:0]   w_rx_next;
    logic [SPI_BITS-1:0]   w_reload_val;

    // A cs that is already low when reset releases must not count as a frame start, so
    // falling edges are ignored until the pin pipeline has been refilled with real samples.
    assign w_armed      = r_flush[SYNC_STAGES];
    assign w_sclk_rise  = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall  = ~w_sclk_s & r_sclk_prev;
    assign w_cs_fall    = w_armed & ~w_cs_s & r_cs_prev;
    assign w_cs_rise    = w_cs_s & ~r_cs_prev;
    assign w_rx_next    = {r_rx_shift, w_mosi_s};
    assign w_reload_val = r_tx_pending ? r_tx_buf : IDLE_FILL;

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_sclk_prev  <= 1'b0;
            r_cs_prev    <= 1'b1;
            r_flush      <= '0;
            r_bit_cnt    <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_tx_buf     <= '0;
            r_tx_pending <= 1'b0;
            r_rx_data    <= '0;
            r_rx_ready   <= 1'b0;
            r_overrun    <= 1'b0;
            r_miso_oe    <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};

            if (rx_ready_clear) r_rx_ready <= 1'b0;
            if (overrun_clear)  r_overrun  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_miso_oe <= 1'b0;
                    if (w_cs_fall) begin
                        r_state      <= ST_SHIFT;
                        r_miso_oe    <= 1'b1;
                        r_bit_cnt    <= '0;
                        r_rx_shift   <= '0;
                        r_tx_shift   <= w_reload_val;
                        r_tx_pending <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state    <= ST_IDLE;
                        r_miso_oe  <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_next[SPI_BITS-2:0];
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        // A completing byte beats a same-cycle clear, and that clear also
                        // cancels the overrun the still-unread byte would otherwise raise.
                        if (r_bit_cnt == LAST_BIT) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_ready <= 1'b1;
                            if (r_rx_ready && !rx_ready_clear) r_overrun <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_bit_cnt != '0) begin
                            r_tx_shift <= {r_tx_shift[SPI_BITS-2:0], 1'b0};
                        end else begin
                            r_tx_shift   <= w_reload_val;
                            r_tx_pending <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (tx_strobe) begin
                r_tx_buf     <= tx_data;
                r_tx_pending <= 1'b1;
            end
        end
    end

    assign spi_miso    = (r_state == ST_SHIFT) ? r_tx_shift[SPI_BITS-1] : 1'b1;
    assign spi_miso_oe = r_miso_oe & ~w_cs_s;
    assign cs_active   = ~w_cs_s;
    assign tx_pending  = r_tx_pending;
    assign rx_data     = r_rx_data;
    assign rx_ready    = r_rx_ready;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a host-side SPI driver, a queue scoreboard for received
// bytes and a frame-level model of the transmit buffer and the ready/overrun flags.
module tb_spi_slave;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_LAT     = SYNC_STAGES + 2;

    logic       raw_clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_strobe = 1'b0;
    logic       tx_pending;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ready_clear;
    logic       overrun;
    logic       overrun_clear = 1'b0;
    logic       cs_active;

    logic       monClear = 1'b0;
    logic       mainClear = 1'b0;

    assign rx_ready_clear = monClear | mainClear;

    spi_slave #(.SYNC_STAGES(SYNC_STAGES), .IDLE_FILL(8'hFF)) dut (
        .raw_clk(raw_clk),
        .reset(reset),
        .spi_sclk(spi_sclk),
        .spi_cs(spi_cs),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data),
        .tx_strobe(tx_strobe),
        .tx_pending(tx_pending),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .rx_ready_clear(rx_ready_clear),
        .overrun(overrun),
        .overrun_clear(overrun_clear),
        .cs_active(cs_active)
    );

    // Free-running raw clock and a cycle counter used to time rx completion latency.
    always #5 raw_clk = ~raw_clk;

    int cycleCount = 0;
    always @(posedge raw_clk) cycleCount <= cycleCount + 1;

    int         nChecks = 0;
    int         nFails = 0;
    logic [7:0] expRx[$];
    bit         modelPending = 1'b0;
    logic [7:0] modelBuf = 8'h00;
    bit         modelRdy = 1'b0;
    bit         modelOvr = 1'b0;
    bit         autoClear = 1'b1;
    int         lastRiseCycle = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Next byte the host should see: the pending buffer if one was strobed, else the fill.
    function automatic logic [7:0] modelNextTx();
        logic [7:0] v;
        v = modelPending ? modelBuf : 8'hFF;
        modelPending = 1'b0;
        return v;
    endfunction

    // Scoreboard monitor: every rising rx_ready must match the oldest expected byte.
    task automatic monitorRx();
        logic prevRdy = 1'b0;
        int   lat;
        forever begin
            @(negedge raw_clk);
            if (rx_ready && !prevRdy) begin
                if (expRx.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL rx_unexpected: got byte 0x%0h, expected no byte at %0t", rx_data, $time);
                end else begin
                    checkOutput("rx_data", {24'h0, rx_data}, {24'h0, expRx.pop_front()});
                end
                lat = cycleCount - lastRiseCycle;
                nChecks++;
                if (lat < 1 || lat > MAX_LAT) begin
                    nFails++;
                    $display("[TB] FAIL rx_latency: got %0d cycles, expected 1..%0d", lat, MAX_LAT);
                end
                monClear = autoClear;
            end else begin
                monClear = 1'b0;
            end
            prevRdy = rx_ready;
        end
    endtask

    task automatic txStrobe(input logic [7:0] d);
        @(negedge raw_clk);
        tx_data   = d;
        tx_strobe = 1'b1;
        @(negedge raw_clk);
        tx_strobe = 1'b0;
        modelBuf     = d;
        modelPending = 1'b1;
    endtask

    // Host side of mode 0 at raw_clk/8: data set while sclk low, miso sampled at the rise.
    task automatic spiByte(input logic [7:0] b, input int nBits, input bit clrAtEnd, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            spi_mosi = b[7-i];
            repeat (4) @(negedge raw_clk);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            lastRiseCycle = cycleCount;
            if (clrAtEnd && i == nBits - 1) begin
                repeat (2) @(negedge raw_clk);
                mainClear = 1'b1;
                @(negedge raw_clk);
                mainClear = 1'b0;
                @(negedge raw_clk);
            end else begin
                repeat (4) @(negedge raw_clk);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic pulseRxClear();
        @(negedge raw_clk);
        mainClear = 1'b1;
        @(negedge raw_clk);
        mainClear = 1'b0;
        modelRdy  = 1'b0;
    endtask

    // One cs-low frame of nBytes back-to-back bytes; expectations come from the model.
    task automatic applyStimulus(input logic [23:0] bytes, input int nBytes, input bit clrLast);
        logic [7:0] b;
        logic [7:0] rx;
        logic [7:0] exp;
        bit         lastClr;
        spi_cs = 1'b0;
        for (int i = 0; i < nBytes; i++) begin
            b       = bytes[23-8*i -: 8];
            exp     = modelNextTx();
            lastClr = clrLast && (i == nBytes - 1);
            if (autoClear || !modelRdy) expRx.push_back(b);
            else if (!lastClr) modelOvr = 1'b1;
            if (!autoClear) modelRdy = 1'b1;
            spiByte(b, 8, lastClr, rx);
            checkOutput("miso_byte", {24'h0, rx}, {24'h0, exp});
            if (i == 0) begin
                checkOutput("miso_oe_in_frame", {31'h0, spi_miso_oe}, 32'h1);
                checkOutput("cs_active_in_frame", {31'h0, cs_active}, 32'h1);
                checkOutput("tx_pending_taken", {31'h0, tx_pending}, 32'h0);
            end
        end
        modelPending = 1'b0;
        repeat (4) @(negedge raw_clk);
        spi_cs = 1'b1;
        repeat (10) @(negedge raw_clk);
        checkOutput("overrun", {31'h0, overrun}, {31'h0, modelOvr});
        checkOutput("tx_pending", {31'h0, tx_pending}, {31'h0, modelPending});
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  rx;
        logic [23:0] rnd;
        int          nb;

        fork
            monitorRx();
        join_none

        repeat (3) @(negedge raw_clk);
        reset = 1'b1;
        repeat (3) @(negedge raw_clk);

        checkOutput("reset_rx_ready", {31'h0, rx_ready}, 32'h0);
        checkOutput("reset_overrun", {31'h0, overrun}, 32'h0);
        checkOutput("reset_tx_pending", {31'h0, tx_pending}, 32'h0);
        checkOutput("reset_miso", {31'h0, spi_miso}, 32'h1);
        checkOutput("reset_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        checkOutput("reset_cs_active", {31'h0, cs_active}, 32'h0);
        checkOutput("reset_rx_data", {24'h0, rx_data}, 32'h0);

        $display("[TB] single byte receive");
        applyStimulus({8'hA5, 16'h0}, 1, 1'b0);

        $display("[TB] transmit strobed byte");
        txStrobe(8'h3C);
        checkOutput("tx_pending_set", {31'h0, tx_pending}, 32'h1);
        applyStimulus({8'h96, 16'h0}, 1, 1'b0);

        $display("[TB] back-to-back bytes without clear");
        autoClear = 1'b0;
        applyStimulus({8'h01, 8'h02, 8'h00}, 2, 1'b0);
        checkOutput("overrun_rx_data", {24'h0, rx_data}, 32'h02);
        checkOutput("overrun_rx_ready", {31'h0, rx_ready}, 32'h1);
        @(negedge raw_clk);
        overrun_clear = 1'b1;
        @(negedge raw_clk);
        overrun_clear = 1'b0;
        modelOvr = 1'b0;
        @(negedge raw_clk);
        checkOutput("overrun_cleared", {31'h0, overrun}, 32'h0);
        pulseRxClear();
        @(negedge raw_clk);
        checkOutput("rx_ready_cleared", {31'h0, rx_ready}, 32'h0);
        autoClear = 1'b1;

        $display("[TB] cs abort mid-byte");
        spi_cs = 1'b0;
        spiByte(8'hB4, 5, 1'b0, rx);
        repeat (4) @(negedge raw_clk);
        spi_cs = 1'b1;
        repeat (10) @(negedge raw_clk);
        checkOutput("abort_no_ready", {31'h0, rx_ready}, 32'h0);
        applyStimulus({8'h81, 16'h0}, 1, 1'b0);
        checkOutput("abort_then_rx_data", {24'h0, rx_data}, 32'h81);

        $display("[TB] ready clear coincident with completion");
        autoClear = 1'b0;
        applyStimulus({8'h5A, 16'h0}, 1, 1'b0);
        applyStimulus({8'h6C, 16'h0}, 1, 1'b1);
        checkOutput("coincident_rx_ready", {31'h0, rx_ready}, 32'h1);
        checkOutput("coincident_rx_data", {24'h0, rx_data}, 32'h6C);
        pulseRxClear();
        autoClear = 1'b1;

        $display("[TB] reset in mid-frame");
        spi_cs = 1'b0;
        spiByte(8'hC3, 4, 1'b0, rx);
        @(negedge raw_clk);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        checkOutput("async_reset_miso", {31'h0, spi_miso}, 32'h1);
        checkOutput("async_reset_rx_data", {24'h0, rx_data}, 32'h0);
        modelPending = 1'b0;
        modelRdy     = 1'b0;
        modelOvr     = 1'b0;
        repeat (2) @(negedge raw_clk);
        reset = 1'b1;
        spiByte(8'h30, 4, 1'b0, rx);
        repeat (4) @(negedge raw_clk);
        checkOutput("post_reset_no_ready", {31'h0, rx_ready}, 32'h0);
        checkOutput("post_reset_miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        checkOutput("post_reset_cs_active", {31'h0, cs_active}, 32'h1);
        spi_cs = 1'b1;
        repeat (10) @(negedge raw_clk);
        applyStimulus({8'hE7, 16'h0}, 1, 1'b0);

        $display("[TB] randomized frames");
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 1) == 1) txStrobe(8'($urandom));
            nb  = $urandom_range(1, 3);
            rnd = 24'($urandom);
            applyStimulus(rnd, nb, 1'b0);
        end

        repeat (20) @(negedge raw_clk);
        checkOutput("rx_queue_drained", expRx.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
